// File: rtl/reset_sequencer_pkg.sv
// Shared types for the reset sequencer: FSM states, reset causes and a counter-width helper.
package reset_seq_pkg;

  typedef enum logic [1:0] {ST_HOLD, ST_RELEASE, ST_RUN} rs_state_t;
  typedef enum logic [1:0] {CAUSE_POR, CAUSE_EXT, CAUSE_BTN, CAUSE_WDT} rs_cause_t;

  // Every counter is one bit wider than needed so the limit itself is representable.
  function automatic int cnt_width(input int limit);
    return $clog2(limit) + 1;
  endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// Board-facing signals of the reset sequencer; master is the sequencer, slave is the surrounding system.
interface reset_sequencer_if
  import reset_seq_pkg::*;
#(
  parameter int NUM_OUT = 3
);

  logic               btn_n_in;
  logic               wdt_en_in;
  logic               wdt_kick_in;
  logic [NUM_OUT-1:0] rst_out;
  logic               ready_out;
  rs_cause_t          cause_out;
  rs_state_t          dbg_state;

  // ready_out is a level, not a handshake: high exactly while the FSM sits in RUN.
  modport master (
    input  btn_n_in, wdt_en_in, wdt_kick_in,
    output rst_out, ready_out, cause_out, dbg_state
  );

  modport slave (
    output btn_n_in, wdt_en_in, wdt_kick_in,
    input  rst_out, ready_out, cause_out, dbg_state
  );

endinterface

// File: rtl/reset_sequencer_btn_debounce.sv
// Push-button conditioning: 2-FF synchroniser, stability counter and a one-cycle press pulse.
module btn_debounce
  import reset_seq_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 8
) (
  input  logic clk_in,
  input  logic reset_in,
  input  logic btn_n_in,
  output logic level_o,
  output logic press_o
);

  localparam int CW = cnt_width(DEBOUNCE_CYC);

  if (DEBOUNCE_CYC < 2) begin : g_bad_debounce
    $error("DEBOUNCE_CYC must be >= 2");
  end

  // All state is stored active-high "pressed" so the all-zero power-up value means released.
  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    level_d = level_q;
    press_d = 1'b0;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYC - 1)) begin
        level_d = sync2_q;
        press_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= ~btn_n_in;
      sync2_q <= sync1_q;
      level_q <= level_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;
  assign press_o = press_q;

endmodule

// File: rtl/reset_sequencer.sv
// Staggered reset generator: HOLD all domains, release them in order, then RUN until a
// reset_in, button or watchdog trigger sends it back to HOLD. Records the last cause.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int NUM_OUT        = 3,
  parameter int HOLD_CYCLES    = 16,
  parameter int STAGGER_CYCLES = 4,
  parameter int DEBOUNCE_CYC   = 8,
  parameter int WDT_TIMEOUT    = 100
) (
  input logic                clk_in,
  input logic                reset_in,
  reset_sequencer_if.master  rs_if
);

  localparam int HOLD_W = cnt_width(HOLD_CYCLES);
  localparam int STAG_W = cnt_width(STAGGER_CYCLES);
  localparam int WDT_W  = cnt_width(WDT_TIMEOUT);

  if (NUM_OUT < 1) begin : g_bad_num_out
    $error("NUM_OUT must be >= 1");
  end
  if (HOLD_CYCLES < 1) begin : g_bad_hold
    $error("HOLD_CYCLES must be >= 1");
  end
  if (STAGGER_CYCLES < 1) begin : g_bad_stagger
    $error("STAGGER_CYCLES must be >= 1");
  end
  if (WDT_TIMEOUT < 2) begin : g_bad_wdt
    $error("WDT_TIMEOUT must be >= 2");
  end

  // rel_q is the released-domain mask (thermometer from bit 0), so zero power-up state = all in reset.
  rs_state_t          state_q, state_d;
  rs_cause_t          cause_q, cause_d;
  logic [NUM_OUT-1:0] rel_q, rel_d, rel_nxt;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [STAG_W-1:0]  stag_q, stag_d;
  logic [WDT_W-1:0]   wdt_q, wdt_d;
  logic               wdt_fire;
  logic               btn_level, btn_press;

  btn_debounce #(
    .DEBOUNCE_CYC (DEBOUNCE_CYC)
  ) u_btn_debounce (
    .clk_in   (clk_in),
    .reset_in (reset_in),
    .btn_n_in (rs_if.btn_n_in),
    .level_o  (btn_level),
    .press_o  (btn_press)
  );

  assign rel_nxt = (rel_q << 1) | NUM_OUT'(1);

  always_comb begin
    state_d  = state_q;
    cause_d  = cause_q;
    rel_d    = rel_q;
    hold_d   = hold_q;
    stag_d   = stag_q;
    wdt_d    = '0;
    wdt_fire = 1'b0;

    // A kick on the timeout cycle clears the counter instead of firing.
    if (state_q == ST_RUN && rs_if.wdt_en_in) begin
      if (rs_if.wdt_kick_in) begin
        wdt_d = '0;
      end else if (wdt_q == WDT_W'(WDT_TIMEOUT)) begin
        wdt_fire = 1'b1;
      end else begin
        wdt_d = wdt_q + 1'b1;
      end
    end

    if (btn_press || wdt_fire) begin
      state_d = ST_HOLD;
      cause_d = btn_press ? CAUSE_BTN : CAUSE_WDT;
      rel_d   = '0;
      hold_d  = '0;
      stag_d  = '0;
      wdt_d   = '0;
    end else begin
      case (state_q)
        ST_HOLD: begin
          if (btn_level) begin
            hold_d = '0;
          end else if (hold_q == HOLD_W'(HOLD_CYCLES - 1)) begin
            hold_d  = '0;
            rel_d   = rel_nxt;
            state_d = (NUM_OUT == 1) ? ST_RUN : ST_RELEASE;
          end else begin
            hold_d = hold_q + 1'b1;
          end
        end
        ST_RELEASE: begin
          if (stag_q == STAG_W'(STAGGER_CYCLES - 1)) begin
            stag_d = '0;
            rel_d  = rel_nxt;
            if (rel_nxt[NUM_OUT-1]) state_d = ST_RUN;
          end else begin
            stag_d = stag_q + 1'b1;
          end
        end
        ST_RUN: ;
        default: begin
          state_d = ST_HOLD;
          rel_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_q <= ST_HOLD;
      cause_q <= CAUSE_EXT;
      rel_q   <= '0;
      hold_q  <= '0;
      stag_q  <= '0;
      wdt_q   <= '0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      rel_q   <= rel_d;
      hold_q  <= hold_d;
      stag_q  <= stag_d;
      wdt_q   <= wdt_d;
    end
  end

  assign rs_if.rst_out   = ~rel_q;
  assign rs_if.ready_out = (state_q == ST_RUN);
  assign rs_if.cause_out = cause_q;
  assign rs_if.dbg_state = state_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: power-up sequence, button, watchdog, reset_in and priority cases.
module tb_reset_sequencer;
  import reset_seq_pkg::*;

  localparam int NUM_OUT = 3;

  logic clk      = 1'b0;
  logic reset_in = 1'b0;
  int   checks   = 0;
  int   failures = 0;
  logic [NUM_OUT-1:0] exp_q[$];

  reset_sequencer_if #(.NUM_OUT(NUM_OUT)) rs_if ();

  reset_sequencer #(
    .NUM_OUT        (NUM_OUT),
    .HOLD_CYCLES    (16),
    .STAGGER_CYCLES (4),
    .DEBOUNCE_CYC   (8),
    .WDT_TIMEOUT    (100)
  ) dut (
    .clk_in   (clk),
    .reset_in (reset_in),
    .rs_if    (rs_if)
  );

  // Clock: posedge at 5, 15, 25 ...; all sampling happens on the falling edge.
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL tb_timeout observed=running expected=finished");
    $fatal(1, "bench time limit exceeded");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_ready(input int limit, input string tag);
    int n = 0;
    while (rs_if.ready_out !== 1'b1 && n < limit) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(rs_if.ready_out), 32'd1);
  endtask

  // Called right after the edge that put the FSM in HOLD with a zero counter.
  task automatic expect_sequence(input string tag);
    logic [NUM_OUT-1:0] exp_v;
    for (int k = 1; k <= 24; k++)
      exp_q.push_back(k < 16 ? 3'b111 : k < 20 ? 3'b110 : k < 24 ? 3'b100 : 3'b000);
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      exp_v = exp_q.pop_front();
      check({tag, "_rst"}, 32'(rs_if.rst_out), 32'(exp_v));
      check({tag, "_ready"}, 32'(rs_if.ready_out), (k == 24) ? 32'd1 : 32'd0);
    end
    check({tag, "_state"}, 32'(rs_if.dbg_state), 32'(ST_RUN));
  endtask

  initial begin
    rs_if.btn_n_in    = 1'b1;
    rs_if.wdt_en_in   = 1'b0;
    rs_if.wdt_kick_in = 1'b0;
    reset_in          = 1'b0;

    // 1. power-up
    #1;
    check("por_rst", 32'(rs_if.rst_out), 32'b111);
    check("por_ready", 32'(rs_if.ready_out), 32'd0);
    check("por_cause", 32'(rs_if.cause_out), 32'(CAUSE_POR));
    check("por_state", 32'(rs_if.dbg_state), 32'(ST_HOLD));
    expect_sequence("por_seq");
    check("por_cause_run", 32'(rs_if.cause_out), 32'(CAUSE_POR));

    // 2. short press is filtered, long press resets
    rs_if.btn_n_in = 1'b0;
    cycles(5);
    rs_if.btn_n_in = 1'b1;
    cycles(15);
    check("short_press_ready", 32'(rs_if.ready_out), 32'd1);
    check("short_press_cause", 32'(rs_if.cause_out), 32'(CAUSE_POR));

    rs_if.btn_n_in = 1'b0;
    cycles(10);
    check("btn_pre_rst", 32'(rs_if.rst_out), 32'b000);
    cycles(1);
    check("btn_rst", 32'(rs_if.rst_out), 32'b111);
    check("btn_cause", 32'(rs_if.cause_out), 32'(CAUSE_BTN));
    check("btn_ready", 32'(rs_if.ready_out), 32'd0);
    cycles(1);
    rs_if.btn_n_in = 1'b1;
    // release accepted 10 edges later, then 16 HOLD edges before bit 0 drops
    cycles(25);
    check("btn_hold_rst", 32'(rs_if.rst_out), 32'b111);
    cycles(1);
    check("btn_rel0_rst", 32'(rs_if.rst_out), 32'b110);
    cycles(7);
    check("btn_pre_run", 32'(rs_if.ready_out), 32'd0);
    cycles(1);
    check("btn_run", 32'(rs_if.ready_out), 32'd1);

    // 3. watchdog timeout, then regular kicks
    rs_if.wdt_en_in = 1'b1;
    cycles(100);
    check("wdt_pre_ready", 32'(rs_if.ready_out), 32'd1);
    cycles(1);
    check("wdt_rst", 32'(rs_if.rst_out), 32'b111);
    check("wdt_cause", 32'(rs_if.cause_out), 32'(CAUSE_WDT));
    wait_ready(40, "wdt_rerun");
    for (int i = 0; i < 20; i++) begin
      cycles(49);
      rs_if.wdt_kick_in = 1'b1;
      cycles(1);
      rs_if.wdt_kick_in = 1'b0;
      check("wdt_kicked_ready", 32'(rs_if.ready_out), 32'd1);
    end

    // 4. kick on the timeout cycle wins, counter restarts from 0
    rs_if.wdt_en_in = 1'b0;
    cycles(1);
    rs_if.wdt_en_in = 1'b1;
    cycles(100);
    rs_if.wdt_kick_in = 1'b1;
    cycles(1);
    rs_if.wdt_kick_in = 1'b0;
    check("kick_at_limit_ready", 32'(rs_if.ready_out), 32'd1);
    cycles(100);
    check("kick_restart_ready", 32'(rs_if.ready_out), 32'd1);
    cycles(1);
    check("kick_restart_rst", 32'(rs_if.rst_out), 32'b111);
    check("kick_restart_cause", 32'(rs_if.cause_out), 32'(CAUSE_WDT));

    // 5. reset_in during RELEASE
    rs_if.wdt_en_in = 1'b0;
    cycles(16);
    check("ext_release_rst", 32'(rs_if.rst_out), 32'b110);
    reset_in = 1'b1;
    cycles(1);
    reset_in = 1'b0;
    check("ext_rst", 32'(rs_if.rst_out), 32'b111);
    check("ext_cause", 32'(rs_if.cause_out), 32'(CAUSE_EXT));
    check("ext_state", 32'(rs_if.dbg_state), 32'(ST_HOLD));
    expect_sequence("ext_seq");
    check("ext_cause_run", 32'(rs_if.cause_out), 32'(CAUSE_EXT));

    // 6. button accept and watchdog timeout on the same edge: button wins
    rs_if.wdt_en_in = 1'b1;
    cycles(90);
    rs_if.btn_n_in = 1'b0;
    cycles(10);
    check("prio_pre_ready", 32'(rs_if.ready_out), 32'd1);
    cycles(1);
    check("prio_rst", 32'(rs_if.rst_out), 32'b111);
    check("prio_cause", 32'(rs_if.cause_out), 32'(CAUSE_BTN));
    rs_if.btn_n_in  = 1'b1;
    rs_if.wdt_en_in = 1'b0;
    wait_ready(80, "wdt_off_rerun");
    cycles(300);
    check("wdt_off_ready", 32'(rs_if.ready_out), 32'd1);
    check("wdt_off_cause", 32'(rs_if.cause_out), 32'(CAUSE_BTN));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
